// File: rtl/rptr_empty_ctrl_sync_pkg.sv
// Shared pointer helpers for the async FIFO read and write controllers.
// Gray/binary conversion and address-width derivation.
package fifo_ptr_pkg;

  localparam int PTR_MAX = 32;

  function automatic int ptr_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Callers zero-extend into PTR_MAX and cast the result back to their
  // own pointer width; the upper zeros do not disturb either conversion.
  function automatic logic [PTR_MAX-1:0] bin2gray(
    input logic [PTR_MAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(
    input logic [PTR_MAX-1:0] g
  );
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_ctrl_sync_if.sv
// Read-side bundle between the FIFO pointer controller and its consumer.
// The slave modport is the controller, the master is the consumer side.
interface rptr_empty_ctrl_sync_if
  import fifo_ptr_pkg::*;
#(
  parameter int DEPTH = 1024
);

  localparam int AW = ptr_aw(DEPTH);

  logic          red_enable;
  logic [AW:0]   wptr_gray_async;
  logic [AW:0]   rptr;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          red_en;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_level;
  logic          underflow;

  modport slave (
    input  red_enable,
    input  wptr_gray_async,
    output rptr,
    output rptr_gray,
    output raddr,
    output red_en,
    output empty,
    output almost_empty,
    output rd_level,
    output underflow
  );

  modport master (
    output red_enable,
    output wptr_gray_async,
    input  rptr,
    input  rptr_gray,
    input  raddr,
    input  red_en,
    input  empty,
    input  almost_empty,
    input  rd_level,
    input  underflow
  );

endinterface

// File: rtl/rptr_empty_ctrl_sync_gray_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Shared by the read and write pointer controllers.
module gray_sync_chain #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  // Shift the pointer through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/rptr_empty_ctrl_sync.sv
// Read-domain pointer, empty and level controller for the async FIFO.
// Synchronises the write Gray pointer and advances the read pointer.
module rptr_empty_ctrl_sync
  import fifo_ptr_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input logic clk_r,
  input logic rst_r_gen,
  rptr_empty_ctrl_sync_if.slave bus
);

  localparam int AW = ptr_aw(DEPTH);
  localparam int PW = AW + 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("AE_THRESH must be 0..DEPTH-1");
  end

  logic [AW:0] wgs;
  logic [AW:0] wbin;
  logic [AW:0] rptr_q;
  logic [AW:0] rgray_q;
  logic [AW:0] rptr_next;
  logic [AW:0] rgray_next;
  logic [AW:0] lvl_next;
  logic [AW:0] level_q;
  logic        empty_q;
  logic        ae_q;
  logic        uf_q;
  logic        rd_ok;

  gray_sync_chain #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wsync (
    .clk (clk_r),
    .rst (rst_r_gen),
    .d   (bus.wptr_gray_async),
    .q   (wgs)
  );

  assign wbin = PW'(gray2bin(PTR_MAX'(wgs)));

  // A read is only honoured while the registered empty flag is clear.
  assign rd_ok = bus.red_enable & ~empty_q;

  // Next pointer, its Gray form and the resulting level; the pointer
  // wraps naturally at 2^(AW+1).
  always_comb begin
    rptr_next  = rptr_q + PW'(rd_ok);
    rgray_next = PW'(bin2gray(PTR_MAX'(rptr_next)));
    lvl_next   = wbin - rptr_next;
  end

  // Pointer and flag registers; reset wins over any read in flight.
  always_ff @(posedge clk_r) begin
    if (rst_r_gen) begin
      rptr_q  <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      rptr_q  <= rptr_next;
      rgray_q <= rgray_next;
      level_q <= lvl_next;
      empty_q <= (rgray_next == wgs);
      ae_q    <= (lvl_next <= PW'(AE_THRESH));
      uf_q    <= uf_q | (bus.red_enable & empty_q);
    end
  end

  assign bus.rptr         = rptr_q;
  assign bus.rptr_gray    = rgray_q;
  assign bus.raddr        = rptr_q[AW-1:0];
  assign bus.red_en       = rd_ok;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_level     = level_q;
  assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_rptr_empty_ctrl_sync.sv
// Self-checking bench for rptr_empty_ctrl_sync (DEPTH=16, 2-stage sync).
// Expected state is queued per cycle and compared after each edge.
module tb_rptr_empty_ctrl_sync;

  localparam int DEPTH = 16;
  localparam int SS    = 2;
  localparam int AET   = 4;
  localparam int MOD   = 2 * DEPTH;

  typedef struct {
    int rptr;
    int gray;
    int lvl;
    bit emp;
    bit ae;
    bit uf;
  } exp_t;

  logic clk_r = 1'b0;
  logic rst_r_gen;

  rptr_empty_ctrl_sync_if #(.DEPTH(DEPTH)) ifc ();

  rptr_empty_ctrl_sync #(
    .WIDTH       (32),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SS),
    .AE_THRESH   (AET)
  ) dut (
    .clk_r     (clk_r),
    .rst_r_gen (rst_r_gen),
    .bus       (ifc.slave)
  );

  always #5 clk_r = ~clk_r;

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "init";
  exp_t  sb[$];

  int m_pipe [SS];
  int m_rptr  = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d",
               phase, tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // One clock cycle: drive, predict, clock, compare.
  task automatic step(input bit rst, input bit re, input int wb);
    exp_t e;
    int   seen;
    bit   rd;
    rst_r_gen           = rst;
    ifc.red_enable      = re;
    ifc.wptr_gray_async = 5'(gray_of(wb % MOD));
    #1;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_pipe[i] = 0;
      m_rptr  = 0;
      m_uf    = 1'b0;
      m_empty = 1'b1;
      e.lvl   = 0;
      e.ae    = 1'b1;
    end else begin
      rd = re && !m_empty;
      chk("red_en", int'(ifc.red_en), int'(rd));
      if (re && m_empty) m_uf = 1'b1;
      m_rptr  = (m_rptr + int'(rd)) % MOD;
      seen    = m_pipe[SS-1];
      e.lvl   = (seen - m_rptr + MOD) % MOD;
      m_empty = (e.lvl == 0);
      e.ae    = (e.lvl <= AET);
      for (int i = SS-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = wb % MOD;
    end
    e.rptr = m_rptr;
    e.gray = gray_of(m_rptr);
    e.emp  = m_empty;
    e.uf   = m_uf;
    sb.push_back(e);
    @(posedge clk_r);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underrun", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rptr", int'(ifc.rptr), e.rptr);
      chk("rptr_gray", int'(ifc.rptr_gray), e.gray);
      chk("raddr", int'(ifc.raddr), e.rptr % DEPTH);
      chk("rd_level", int'(ifc.rd_level), e.lvl);
      chk("empty", int'(ifc.empty), int'(e.emp));
      chk("almost_empty", int'(ifc.almost_empty), int'(e.ae));
      chk("underflow", int'(ifc.underflow), int'(e.uf));
      chk("lvl_bound", int'(ifc.rd_level <= DEPTH), 1);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
  endtask

  initial begin
    int          k;
    int          wb;
    logic [4:0]  pg;
    rst_r_gen           = 1'b1;
    ifc.red_enable      = 1'b0;
    ifc.wptr_gray_async = '0;

    phase = "reset";
    do_reset();
    chk("rst_empty", int'(ifc.empty), 1);
    chk("rst_ae", int'(ifc.almost_empty), 1);
    chk("rst_lvl", int'(ifc.rd_level), 0);
    chk("rst_rptr", int'(ifc.rptr), 0);
    chk("rst_uf", int'(ifc.underflow), 0);

    phase = "latency";
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 1);
      if (k == 0 && ifc.empty == 1'b0) k = i;
    end
    chk("edges_to_nonempty", k, SS + 1);
    chk("lvl_one", int'(ifc.rd_level), 1);
    step(1'b0, 1'b1, 1);
    chk("last_read_empty", int'(ifc.empty), 1);
    chk("last_read_rptr", int'(ifc.rptr), 1);
    chk("last_read_gray", int'(ifc.rptr_gray), 1);

    phase = "full";
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16);
    chk("full_lvl", int'(ifc.rd_level), 16);
    chk("full_ae", int'(ifc.almost_empty), 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16);
    chk("drain_lvl", int'(ifc.rd_level), 4);
    chk("drain_ae", int'(ifc.almost_empty), 1);

    phase = "wrap";
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3);
    wb = 3;
    for (int i = 0; i < 40; i++) begin
      wb++;
      pg = ifc.rptr_gray;
      step(1'b0, 1'b1, wb);
      chk("no_empty", int'(ifc.empty), 0);
      chk("gray_1bit", int'($countones(pg ^ ifc.rptr_gray) <= 1), 1);
    end
    chk("wrap_rptr", int'(ifc.rptr), 40 % MOD);

    phase = "underflow";
    do_reset();
    step(1'b0, 1'b1, 0);
    chk("uf_rptr", int'(ifc.rptr), 0);
    chk("uf_set", int'(ifc.underflow), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2);
    chk("uf_sticky", int'(ifc.underflow), 1);

    phase = "mid_reset";
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 7);
    chk("pre_lvl", int'(ifc.rd_level), 7);
    step(1'b1, 1'b1, 7);
    chk("mr_rptr", int'(ifc.rptr), 0);
    chk("mr_empty", int'(ifc.empty), 1);
    chk("mr_lvl", int'(ifc.rd_level), 0);
    for (int i = 0; i < SS + 1; i++) step(1'b0, 1'b0, 7);
    chk("mr_reseen_lvl", int'(ifc.rd_level), 7);
    chk("mr_reseen_empty", int'(ifc.empty), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
